atm_timeout_ctrl: RTL and testbench

ATM_TIMEOUT_CTRL -- requirements
Module: atm_timeout_ctrl

---
 rtl/atm_timeout_pkg.sv | 22 ++
 rtl/atm_timeout_ctrl_counter.sv | 31 +++
 rtl/atm_timeout_ctrl.sv | 130 +++++++++++++
 tb/tb_atm_timeout_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_timeout_pkg.sv
// ATM session timeout: shared phase codes, FSM encoding and
// reset-default timeout thresholds (in clock cycles).
package atm_timeout_pkg;

   typedef enum logic [1:0] {
      PH_NONE = 2'd0,
      PH_CARD = 2'd1,
      PH_PIN  = 2'd2,
      PH_CASH = 2'd3
   } phase_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRE  = 2'd2
   } state_e;

   localparam int unsigned THR_CARD_DEF = 30;
   localparam int unsigned THR_PIN_DEF  = 20;
   localparam int unsigned THR_CASH_DEF = 15;

endpackage

// File: rtl/atm_timeout_ctrl_counter.sv
// Cycle counter with terminal compare for the timeout FSM.
// Ports: clk, rst (async, active-low), clear, enable, limit, hit.
import atm_timeout_pkg::*;

module timeout_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // hit flags the last counting cycle; limit is never 0 while armed
   assign hit = (count == limit - CNT_W'(1));

endmodule

// File: rtl/atm_timeout_ctrl.sv
// ATM per-phase inactivity timeout controller with programmable thresholds.
// Ports: clk, rst (async, active-low), start/phase_req (arm), activity,
//   cancel, cfg_wr/cfg_sel/cfg_data (threshold write), busy,
//   active_phase, expired (1-cycle pulse), expired_phase, remaining.
import atm_timeout_pkg::*;

module atm_timeout_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       phase_req,
   input  logic             activity,
   input  logic             cancel,
   input  logic             cfg_wr,
   input  logic [1:0]       cfg_sel,
   input  logic [CNT_W-1:0] cfg_data,
   output logic             busy,
   output logic [1:0]       active_phase,
   output logic             expired,
   output logic [1:0]       expired_phase,
   output logic [CNT_W-1:0] remaining
);

   state_e           state, state_n;
   logic [CNT_W-1:0] thr [3];
   logic [CNT_W-1:0] req_thr;
   logic [CNT_W-1:0] lim_q;
   logic             req_ok;
   logic             arm, restart, cnt_en, hit;
   logic             cnt_clr;

   always_comb begin
      req_thr = '0;
      unique case (phase_req)
         PH_CARD: req_thr = thr[0];
         PH_PIN:  req_thr = thr[1];
         PH_CASH: req_thr = thr[2];
         default: req_thr = '0;
      endcase
   end

   assign req_ok = (phase_req != PH_NONE) && (req_thr != '0);

   // cancel > start > activity > expiry
   always_comb begin
      state_n = state;
      arm     = 1'b0;
      restart = 1'b0;
      cnt_en  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!cancel && start && req_ok) begin
               state_n = ST_ARMED;
               arm     = 1'b1;
            end
         end
         ST_ARMED: begin
            if (cancel) begin
               state_n = ST_IDLE;
            end else if (start) begin
               if (req_ok) arm = 1'b1;
               else state_n = ST_IDLE;
            end else if (activity) begin
               restart = 1'b1;
            end else if (hit) begin
               state_n = ST_FIRE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_FIRE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   assign cnt_clr = arm || restart || (state_n != ST_ARMED);

   timeout_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .limit  (lim_q),
      .hit    (hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         thr[0]        <= CNT_W'(THR_CARD_DEF);
         thr[1]        <= CNT_W'(THR_PIN_DEF);
         thr[2]        <= CNT_W'(THR_CASH_DEF);
         lim_q         <= '0;
         busy          <= 1'b0;
         active_phase  <= PH_NONE;
         remaining     <= '0;
         expired       <= 1'b0;
         expired_phase <= PH_NONE;
      end else begin
         state   <= state_n;
         busy    <= (state_n == ST_ARMED);
         expired <= (state_n == ST_FIRE);
         if (state_n == ST_FIRE) expired_phase <= active_phase;
         // remaining tracks lim_q - count without a subtractor
         if (state_n != ST_ARMED) begin
            active_phase <= PH_NONE;
            remaining    <= '0;
         end else if (arm) begin
            active_phase <= phase_req;
            lim_q        <= req_thr;
            remaining    <= req_thr;
         end else if (restart) begin
            remaining <= lim_q;
         end else if (cnt_en) begin
            remaining <= remaining - CNT_W'(1);
         end
         if (cfg_wr) begin
            unique case (cfg_sel)
               2'd1:    thr[0] <= cfg_data;
               2'd2:    thr[1] <= cfg_data;
               2'd3:    thr[2] <= cfg_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_atm_timeout_ctrl.sv
// Self-checking bench for atm_timeout_ctrl: directed scenarios plus
// random traffic against a deadline-based reference model.
module tb_atm_timeout_ctrl;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, activity = 1'b0, cancel = 1'b0, cfg_wr = 1'b0;
   logic [1:0] phase_req = '0, cfg_sel = '0;
   logic [W-1:0] cfg_data = '0;
   logic busy, expired;
   logic [1:0] active_phase, expired_phase;
   logic [W-1:0] remaining;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   atm_timeout_ctrl #(.CNT_W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .phase_req     (phase_req),
      .activity      (activity),
      .cancel        (cancel),
      .cfg_wr        (cfg_wr),
      .cfg_sel       (cfg_sel),
      .cfg_data      (cfg_data),
      .busy          (busy),
      .active_phase  (active_phase),
      .expired       (expired),
      .expired_phase (expired_phase),
      .remaining     (remaining)
   );

   // Model: an armed phase expires when the cycle index reaches
   // (last arm/activity cycle + threshold).
   bit         m_armed, m_fire;
   logic [1:0] m_ph, m_xph;
   int         m_lim, m_last, cyc;
   int         m_thr [1:3];

   logic [W+5:0] dut_v, exp_v;
   assign dut_v = {busy, active_phase, expired, expired_phase, remaining};
   assign exp_v = {m_armed, (m_armed ? m_ph : 2'd0), m_fire, m_xph,
                   (m_armed ? W'(m_lim - (cyc - m_last - 1)) : W'(0))};

   task automatic model_reset;
      m_armed = 0; m_fire = 0; m_ph = 0; m_xph = 0;
      m_lim = 0; m_last = 0; cyc = 0;
      m_thr[1] = 30; m_thr[2] = 20; m_thr[3] = 15;
   endtask

   task automatic tick(input logic s, input logic [1:0] p, input logic a,
                       input logic c, input logic w, input logic [1:0] sl,
                       input logic [W-1:0] d);
      bit nf;
      bit ok;
      start = s; phase_req = p; activity = a; cancel = c;
      cfg_wr = w; cfg_sel = sl; cfg_data = d;
      @(posedge clk);
      nf = 0;
      if (c) begin
         m_armed = 0;
      end else if (s && !m_fire) begin
         ok = 0;
         if (p != 0) ok = (m_thr[p] != 0);
         if (ok) begin
            m_armed = 1; m_ph = p; m_lim = m_thr[p]; m_last = cyc;
         end else begin
            m_armed = 0;
         end
      end else if (m_armed && a) begin
         m_last = cyc;
      end else if (m_armed && cyc == m_last + m_lim) begin
         m_armed = 0; nf = 1; m_xph = m_ph;
      end
      m_fire = nf;
      if (w && sl != 0) m_thr[sl] = int'(d);
      cyc++;
      #1;
   endtask

   task automatic idle;
      tick(0, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (dut_v !== '0) begin
         bad++; $display("FAIL reset_outs act=%h req=0", dut_v);
      end
      #2 rst = 1'b1;
      model_reset();
      idle();
      total++;
      if (dut_v !== exp_v) begin
         bad++; $display("FAIL reset_idle act=%h req=%h", dut_v, exp_v);
      end
   endtask

   task automatic test_basic;
      tick(1, 2, 0, 0, 0, 0, '0);
      total++;
      if (busy !== 1'b1 || remaining !== W'(20)) begin
         bad++; $display("FAIL basic_arm act=%b/%0d req=1/20", busy, remaining);
      end
      for (int i = 0; i < 19; i++) begin
         idle();
         total++;
         if (expired !== 1'b0 || dut_v !== exp_v) begin
            bad++; $display("FAIL basic_wait act=%h req=%h", dut_v, exp_v);
         end
      end
      idle();
      total++;
      if (expired !== 1'b1 || expired_phase !== 2'd2) begin
         bad++; $display("FAIL basic_fire act=%b/%0d req=1/2", expired, expired_phase);
      end
      idle();
      total++;
      if (busy !== 1'b0 || expired !== 1'b0) begin
         bad++; $display("FAIL basic_done act=%b%b req=00", busy, expired);
      end
   endtask

   task automatic test_activity;
      tick(1, 1, 0, 0, 0, 0, '0);
      repeat (25) idle();
      tick(0, 0, 1, 0, 0, 0, '0);
      total++;
      if (remaining !== W'(30)) begin
         bad++; $display("FAIL act_restart act=%0d req=30", remaining);
      end
      for (int i = 0; i < 29; i++) begin
         idle();
         total++;
         if (expired !== 1'b0 || dut_v !== exp_v) begin
            bad++; $display("FAIL act_wait act=%h req=%h", dut_v, exp_v);
         end
      end
      idle();
      total++;
      if (expired !== 1'b1 || expired_phase !== 2'd1) begin
         bad++; $display("FAIL act_fire act=%b/%0d req=1/1", expired, expired_phase);
      end
      idle();
   endtask

   task automatic test_rearm;
      tick(1, 1, 0, 0, 0, 0, '0);
      repeat (10) idle();
      tick(1, 3, 0, 0, 0, 0, '0);
      total++;
      if (active_phase !== 2'd3 || remaining !== W'(15)) begin
         bad++; $display("FAIL rearm act=%0d/%0d req=3/15", active_phase, remaining);
      end
      for (int i = 0; i < 14; i++) begin
         idle();
         total++;
         if (expired !== 1'b0 || dut_v !== exp_v) begin
            bad++; $display("FAIL rearm_wait act=%h req=%h", dut_v, exp_v);
         end
      end
      idle();
      total++;
      if (expired !== 1'b1 || expired_phase !== 2'd3) begin
         bad++; $display("FAIL rearm_fire act=%b/%0d req=1/3", expired, expired_phase);
      end
      idle();
   endtask

   task automatic test_cancel_activity;
      bit seen;
      tick(1, 2, 0, 0, 0, 0, '0);
      repeat (5) idle();
      tick(1, 1, 0, 1, 0, 0, '0);
      total++;
      if (busy !== 1'b0 || active_phase !== 2'd0) begin
         bad++; $display("FAIL cancel_start act=%b/%0d req=0/0", busy, active_phase);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         idle();
         if (expired) seen = 1;
      end
      total++;
      if (seen) begin
         bad++; $display("FAIL cancel_noexp act=1 req=0");
      end
      tick(1, 3, 0, 0, 0, 0, '0);
      repeat (14) idle();
      tick(0, 0, 1, 0, 0, 0, '0);
      total++;
      if (busy !== 1'b1 || remaining !== W'(15) || expired !== 1'b0) begin
         bad++; $display("FAIL act_at_exp act=%b/%0d/%b req=1/15/0", busy, remaining, expired);
      end
      for (int i = 0; i < 16; i++) begin
         idle();
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL act_at_exp_run act=%h req=%h", dut_v, exp_v);
         end
      end
   endtask

   task automatic test_cfg;
      tick(0, 0, 0, 0, 1, 3, W'(5));
      tick(1, 3, 0, 0, 0, 0, '0);
      for (int i = 0; i < 4; i++) begin
         idle();
         total++;
         if (expired !== 1'b0 || dut_v !== exp_v) begin
            bad++; $display("FAIL cfg_wait act=%h req=%h", dut_v, exp_v);
         end
      end
      idle();
      total++;
      if (expired !== 1'b1 || expired_phase !== 2'd3) begin
         bad++; $display("FAIL cfg_fire act=%b/%0d req=1/3", expired, expired_phase);
      end
      idle();
      tick(0, 0, 0, 0, 1, 3, '0);
      tick(1, 3, 0, 0, 0, 0, '0);
      total++;
      if (busy !== 1'b0 || dut_v !== exp_v) begin
         bad++; $display("FAIL cfg_zero act=%h req=%h", dut_v, exp_v);
      end
      tick(0, 0, 0, 0, 1, 3, W'(15));
   endtask

   task automatic test_random;
      logic s, a, c, w;
      logic [1:0] p, sl;
      logic [W-1:0] d;
      for (int i = 0; i < 3000; i++) begin
         s  = ($urandom_range(0, 29) == 0);
         p  = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 24) == 0);
         c  = ($urandom_range(0, 59) == 0);
         w  = ($urandom_range(0, 39) == 0);
         sl = 2'($urandom_range(0, 3));
         d  = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 40));
         tick(s, p, a, c, w, sl, d);
         total++;
         if (dut_v !== exp_v) begin
            bad++; $display("FAIL random cyc=%0d act=%h req=%h", cyc, dut_v, exp_v);
         end
      end
      tick(0, 0, 0, 1, 0, 0, '0);
      idle();
   endtask

   task automatic test_reset_mid;
      int defs [1:3];
      defs[1] = 30; defs[2] = 20; defs[3] = 15;
      tick(1, 1, 0, 0, 0, 0, '0);
      repeat (5) idle();
      #2 rst = 1'b0;
      #1;
      total++;
      if (dut_v !== '0) begin
         bad++; $display("FAIL reset_mid act=%h req=0", dut_v);
      end
      model_reset();
      #1 rst = 1'b1;
      for (int p = 1; p <= 3; p++) begin
         tick(1, 2'(p), 0, 0, 0, 0, '0);
         total++;
         if (remaining !== W'(defs[p]) || dut_v !== exp_v) begin
            bad++; $display("FAIL reset_def p=%0d act=%0d req=%0d", p, remaining, defs[p]);
         end
         tick(0, 0, 0, 1, 0, 0, '0);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_activity();
      test_rearm();
      test_cancel_activity();
      test_cfg();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
